pool2d_stream: RTL and testbench

- Streaming 2-D non-overlapping pooling engine for the CNN datapath; the next generation of the fixed max-pooler.
- Accepts one pixel per enabled cycle in raster order from a square IMG_W x IMG_W feature map and emits one pooled value per POOL x POOL window.
- Adds selectable max/average mode, signed/unsigned compare, parametrised data width and window size, and automatic frame-to-frame restart.
- Sits between the convolution/ReLU stage and the next layer's input buffer.

---
 rtl/pool2d_stream.sv | 126 ++++++++++++
 tb/tb_pool2d_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pool2d_stream.sv
// Streaming non-overlapping POOL x POOL pooling over an IMG_W x IMG_W raster frame.
// Horizontal partials live in one accumulator; vertical partials live in a line
// buffer with one entry per window column. Max or average, signed or unsigned.
module pool2d_stream #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMG_W  = 12,
    parameter int unsigned POOL   = 3,
    parameter int unsigned MODE   = 0,
    parameter int unsigned SIGNED = 1
) (
    input  logic              clk,
    input  logic              master_rst,
    input  logic              ce,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_op,
    output logic              end_op
);

    localparam int unsigned LOG2P = $clog2(POOL);
    // Average mode widens the accumulator so a full window sum cannot overflow
    localparam int unsigned SH    = (MODE == 1) ? 2 * LOG2P : 0;
    localparam int unsigned ACC_W = DATA_W + SH;
    localparam int unsigned NW    = IMG_W / POOL;
    localparam int unsigned PW    = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int unsigned WW    = (NW > 1) ? $clog2(NW) : 1;

    if (IMG_W % POOL != 0) begin : g_bad_img
        $error("pool2d_stream: IMG_W must be a multiple of POOL");
    end
    if (MODE == 1 && POOL != 2 && POOL != 4) begin : g_bad_avg
        $error("pool2d_stream: average mode needs POOL of 2 or 4");
    end

    // Position inside the window (hcnt/vcnt) and window index (wcol/wrow)
    logic [PW-1:0]     hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [WW-1:0]     wcol_q, wcol_d, wrow_q, wrow_d;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  line_q [NW];
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, end_q, end_d;

    logic              h_last, c_last, v_last, r_last;
    logic [ACC_W-1:0]  pix_ext, h_part, v_part;
    logic [DATA_W-1:0] result;

    function automatic logic [ACC_W-1:0] extend(input logic [DATA_W-1:0] v);
        if (SIGNED != 0) return ACC_W'($signed(v));
        else return ACC_W'(v);
    endfunction

    function automatic logic [ACC_W-1:0] combine(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        if (MODE == 1) return a + b;
        else if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
        else return (a > b) ? a : b;
    endfunction

    // Datapath: horizontal partial, vertical partial and the scaled window result
    always_comb begin
        h_last  = (hcnt_q == PW'(POOL - 1));
        c_last  = h_last && (wcol_q == WW'(NW - 1));
        v_last  = (vcnt_q == PW'(POOL - 1));
        r_last  = v_last && (wrow_q == WW'(NW - 1));
        pix_ext = extend(data_in);
        // Windows start by loading, never from zero, so all-negative maxima work
        h_part  = (hcnt_q == '0) ? pix_ext : combine(acc_q, pix_ext);
        v_part  = (vcnt_q == '0) ? h_part : combine(line_q[wcol_q], h_part);
        if (SIGNED != 0) result = DATA_W'($signed(v_part) >>> SH);
        else result = DATA_W'(v_part >> SH);
    end

    // Next-state for counters and output registers; ce=0 holds everything
    always_comb begin
        hcnt_d  = hcnt_q;
        wcol_d  = wcol_q;
        vcnt_d  = vcnt_q;
        wrow_d  = wrow_q;
        data_d  = data_q;
        valid_d = 1'b0;
        end_d   = 1'b0;
        if (ce) begin
            hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
            if (h_last) wcol_d = c_last ? '0 : wcol_q + 1'b1;
            if (c_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            if (c_last && v_last) wrow_d = r_last ? '0 : wrow_q + 1'b1;
            if (h_last && v_last) begin
                data_d  = result;
                valid_d = 1'b1;
                end_d   = c_last && r_last;
            end
        end
    end

    // State registers, accumulator and line buffer
    always_ff @(posedge clk or negedge master_rst) begin
        if (!master_rst) begin
            hcnt_q  <= '0;
            wcol_q  <= '0;
            vcnt_q  <= '0;
            wrow_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            for (int i = 0; i < int'(NW); i++) line_q[i] <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            wcol_q  <= wcol_d;
            vcnt_q  <= vcnt_d;
            wrow_q  <= wrow_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            end_q   <= end_d;
            if (ce) begin
                acc_q <= h_part;
                if (h_last) line_q[wcol_q] <= v_part;
            end
        end
    end

    assign data_out = data_q;
    assign valid_op = valid_q;
    assign end_op   = end_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench: 4x4/2 max and average instances share stimulus, the default
// 12x12/3 max instance gets random frames with random ce gaps and a mid-frame reset.
module tb_pool2d_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce4, ce12;
    logic [31:0] din4, din12;
    logic [31:0] dout_mx, dout_av, dout12;
    logic        vmx, vav, v12, emx, eav, e12;

    int checks = 0;
    int errors = 0;

    logic [31:0] pix4 [16];
    logic [31:0] emax4 [4];
    logic [31:0] eavg4 [4];
    logic [31:0] pix12 [144];
    logic [31:0] emax12 [16];

    always #5 clk = ~clk;

    pool2d_stream #(.DATA_W(32), .IMG_W(4), .POOL(2), .MODE(0), .SIGNED(1)) u_mx (
        .clk(clk), .master_rst(rst_n), .ce(ce4), .data_in(din4),
        .data_out(dout_mx), .valid_op(vmx), .end_op(emx)
    );

    pool2d_stream #(.DATA_W(32), .IMG_W(4), .POOL(2), .MODE(1), .SIGNED(1)) u_av (
        .clk(clk), .master_rst(rst_n), .ce(ce4), .data_in(din4),
        .data_out(dout_av), .valid_op(vav), .end_op(eav)
    );

    pool2d_stream u_def (
        .clk(clk), .master_rst(rst_n), .ce(ce12), .data_in(din12),
        .data_out(dout12), .valid_op(v12), .end_op(e12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One 4x4 frame, continuous ce; ce is left high so frames run back to back
    task automatic run4();
        int k = 0;
        for (int i = 0; i < 16; i++) begin
            ce4  = 1'b1;
            din4 = pix4[i];
            @(posedge clk);
            #1;
            if ((i % 2 == 1) && ((i / 4) % 2 == 1)) begin
                check("mx valid", 32'(vmx), 32'd1);
                check("av valid", 32'(vav), 32'd1);
                check("mx data", dout_mx, emax4[k]);
                check("av data", dout_av, eavg4[k]);
                check("mx end", 32'(emx), 32'(k == 3));
                check("av end", 32'(eav), 32'(k == 3));
                k++;
            end else begin
                check("mx no valid", 32'(vmx), 32'd0);
                check("av no valid", 32'(vav), 32'd0);
            end
        end
        check("4x4 window count", 32'(k), 32'd4);
    endtask

    // Fresh random signed frame and its window maxima
    task automatic gen12();
        logic [31:0] m, p;
        for (int i = 0; i < 144; i++) pix12[i] = $urandom;
        for (int w = 0; w < 16; w++) begin
            m = pix12[(w / 4) * 36 + (w % 4) * 3];
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    p = pix12[((w / 4) * 3 + r) * 12 + (w % 4) * 3 + c];
                    if ($signed(p) > $signed(m)) m = p;
                end
            emax12[w] = m;
        end
    endtask

    // One 12x12 frame with ce randomly dropped gap_pct percent of the time
    task automatic run12(input int gap_pct);
        int k = 0;
        int ends = 0;
        for (int i = 0; i < 144; i++) begin
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
                ce12 = 1'b0;
                @(posedge clk);
                #1;
                check("def idle valid", 32'(v12), 32'd0);
                check("def idle end", 32'(e12), 32'd0);
            end
            ce12  = 1'b1;
            din12 = pix12[i];
            @(posedge clk);
            #1;
            if (e12) ends++;
            if ((i % 3 == 2) && ((i / 12) % 3 == 2)) begin
                check("def valid", 32'(v12), 32'd1);
                check("def data", dout12, emax12[k]);
                check("def end", 32'(e12), 32'(k == 15));
                k++;
            end else begin
                check("def no valid", 32'(v12), 32'd0);
            end
        end
        check("def window count", 32'(k), 32'd16);
        check("def end count", 32'(ends), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ce4   = 1'b0;
        ce12  = 1'b0;
        din4  = '0;
        din12 = '0;
        #12;
        check("rst mx data", dout_mx, 32'd0);
        check("rst mx valid", 32'(vmx), 32'd0);
        check("rst av data", dout_av, 32'd0);
        check("rst mx end", 32'(emx), 32'd0);
        check("rst def data", dout12, 32'd0);
        check("rst def valid", 32'(v12), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp 1..16: max 6,8,14,16; average floor 3.5,5.5,11.5,13.5
        for (int i = 0; i < 16; i++) pix4[i] = 32'(i + 1);
        emax4 = '{32'd6, 32'd8, 32'd14, 32'd16};
        eavg4 = '{32'd3, 32'd5, 32'd11, 32'd13};
        run4();

        // All -5 back to back: a zero-initialised max would give 0
        for (int i = 0; i < 16; i++) pix4[i] = 32'hFFFF_FFFB;
        emax4 = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        eavg4 = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        run4();

        // All -3
        for (int i = 0; i < 16; i++) pix4[i] = 32'hFFFF_FFFD;
        emax4 = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
        eavg4 = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
        run4();

        // Every window {-1,-2,-1,-2}: max -1, average floor(-1.5) = -2
        for (int i = 0; i < 16; i++) pix4[i] = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
        emax4 = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        eavg4 = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        run4();
        ce4 = 1'b0;
        @(posedge clk);
        #1;
        check("mx idle after frames", 32'(vmx), 32'd0);

        // Defaults with ~40% ce gaps
        gen12();
        run12(40);
        ce12 = 1'b0;

        // Partial frame up to mid row 4, then asynchronous reset
        gen12();
        for (int i = 0; i < 54; i++) begin
            ce12  = 1'b1;
            din12 = pix12[i];
            @(posedge clk);
            #1;
        end
        check("pre-rst def data", dout12, emax12[3]);
        ce12 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst def data", dout12, 32'd0);
        check("mid rst def valid", 32'(v12), 32'd0);
        @(posedge clk);
        #1;
        check("held rst def data", dout12, 32'd0);
        check("held rst def valid", 32'(v12), 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // New frame after reset, then two more frames back to back with no gap
        gen12();
        run12(0);
        gen12();
        run12(0);
        gen12();
        run12(0);
        ce12 = 1'b0;
        @(posedge clk);
        #1;
        check("def idle after frames", 32'(v12), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
